// File: rtl/lns_mul_stage_pkg.sv
// Shared LNS word definitions: sign + two's-complement log2 field, zero code and saturation limit.
package lns_mul_stage_pkg;

  localparam int LNS_WIDTH     = 12;
  localparam int LNS_FRAC_BITS = 7;

  localparam logic [LNS_WIDTH-2:0] LNS_ZERO_CODE = 11'h400;
  localparam logic [LNS_WIDTH-2:0] LNS_LOG_MAX   = 11'h3FF;

  typedef struct packed {
    logic                 sign;
    logic [LNS_WIDTH-2:0] log;
  } lns_t;

  // Zero code is the most negative log value: only bit (width-2) set.
  function automatic logic is_zero(input logic [31:0] log_field, input int width);
    return log_field == (32'd1 << (width - 2));
  endfunction

endpackage

// File: rtl/lns_mul_stage_if.sv
// Operand/result handshake bundle for the LNS multiply stage.
interface lns_mul_stage_if #(
  parameter int WIDTH = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_c;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_p;
  logic [WIDTH-1:0] out_c;

  modport master (
    output in_valid, in_a, in_b, in_c, out_ready,
    input  in_ready, out_valid, out_p, out_c
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, out_ready,
    output in_ready, out_valid, out_p, out_c
  );
endinterface

// File: rtl/lns_log_mul.sv
// Combinational LNS multiply: sign XOR plus saturating log add with underflow to the zero code.
module lns_log_mul
  import lns_mul_stage_pkg::*;
#(
  parameter int WIDTH = LNS_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             za,
  input  logic             zb,
  output logic [WIDTH-1:0] p,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-2:0] ZERO_CODE = {1'b1, {(WIDTH-2){1'b0}}};
  localparam logic [WIDTH-2:0] LOG_MAX   = {1'b0, {(WIDTH-2){1'b1}}};
  localparam logic signed [WIDTH-1:0] SUM_HI = signed'({2'b00, {(WIDTH-2){1'b1}}});
  localparam logic signed [WIDTH-1:0] SUM_LO = signed'({2'b11, {(WIDTH-2){1'b0}}});

  logic signed [WIDTH-1:0] sum;
  logic                    sign;

  assign sum  = signed'({a[WIDTH-2], a[WIDTH-2:0]}) + signed'({b[WIDTH-2], b[WIDTH-2:0]});
  assign sign = a[WIDTH-1] ^ b[WIDTH-1];

  always_comb begin
    p   = {sign, sum[WIDTH-2:0]};
    ovf = 1'b0;
    unf = 1'b0;
    if (za || zb) begin
      p = {1'b0, ZERO_CODE};
    end else if (sum > SUM_HI) begin
      p   = {sign, LOG_MAX};
      ovf = 1'b1;
    end else if (sum <= SUM_LO) begin
      p   = {1'b0, ZERO_CODE};
      unf = 1'b1;
    end
  end

endmodule

// File: rtl/lns_mul_stage.sv
// Two-stage pipelined LNS multiply front-end feeding the LNS adder (p = a*b, c delay-matched).
// Optional sticky overflow/underflow flags are built when LNS_MUL_FLAGS_EN is defined.
module lns_mul_stage
  import lns_mul_stage_pkg::*;
#(
  parameter int WIDTH     = LNS_WIDTH,
  parameter int FRAC_BITS = LNS_FRAC_BITS
) (
  input  logic clk,
  input  logic rst,
`ifdef LNS_MUL_FLAGS_EN
  input  logic flag_clr,
  output logic flag_ovf,
  output logic flag_unf,
`endif
  lns_mul_stage_if.slave bus
);

  if (WIDTH < 4 || FRAC_BITS > WIDTH - 2) begin : g_param_check
    $error("lns_mul_stage: unsupported WIDTH/FRAC_BITS combination");
  end

  logic             s1_v, s2_v;
  logic             s1_load, s2_load, out_fire;
  logic [WIDTH-1:0] s1_a, s1_b, s1_c;
  logic             s1_za, s1_zb;
  logic [WIDTH-1:0] s2_p, s2_c;
  logic [WIDTH-1:0] prod;
  logic             prod_ovf, prod_unf;

  // Each stage refills whenever its own contents leave, giving one transfer per cycle.
  assign s2_load      = !s2_v || bus.out_ready;
  assign s1_load      = !s1_v || s2_load;
  assign out_fire     = s2_v && bus.out_ready;
  assign bus.in_ready = s1_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v  <= 1'b0;
      s1_a  <= '0;
      s1_b  <= '0;
      s1_c  <= '0;
      s1_za <= 1'b0;
      s1_zb <= 1'b0;
    end else if (s1_load) begin
      s1_v <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a  <= bus.in_a;
        s1_b  <= bus.in_b;
        s1_c  <= bus.in_c;
        s1_za <= is_zero(32'(bus.in_a[WIDTH-2:0]), WIDTH);
        s1_zb <= is_zero(32'(bus.in_b[WIDTH-2:0]), WIDTH);
      end
    end
  end

  lns_log_mul #(.WIDTH(WIDTH)) u_log_mul (
    .a   (s1_a),
    .b   (s1_b),
    .za  (s1_za),
    .zb  (s1_zb),
    .p   (prod),
    .ovf (prod_ovf),
    .unf (prod_unf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v <= 1'b0;
      s2_p <= '0;
      s2_c <= '0;
    end else if (s2_load) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_p <= prod;
        s2_c <= s1_c;
      end
    end
  end

  assign bus.out_valid = s2_v;
  assign bus.out_p     = s2_p;
  assign bus.out_c     = s2_c;

`ifdef LNS_MUL_FLAGS_EN
  logic s2_ovf, s2_unf;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_ovf <= 1'b0;
      s2_unf <= 1'b0;
    end else if (s2_load && s1_v) begin
      s2_ovf <= prod_ovf;
      s2_unf <= prod_unf;
    end
  end

  // A path flag only counts once its product is actually handed downstream; set beats clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_ovf <= 1'b0;
      flag_unf <= 1'b0;
    end else begin
      if (out_fire && s2_ovf)  flag_ovf <= 1'b1;
      else if (flag_clr)       flag_ovf <= 1'b0;
      if (out_fire && s2_unf)  flag_unf <= 1'b1;
      else if (flag_clr)       flag_unf <= 1'b0;
    end
  end
`else
  logic unused_path_flags;
  assign unused_path_flags = prod_ovf | prod_unf | out_fire;
`endif

endmodule
